// File: rtl/leaf_nn_search.sv
// KD-tree leaf stage: fetches the LEAF_SIZE candidates of the resolved leaf and
// returns the candidate with the minimum SAD distance to the query.
module leaf_nn_search #(
    parameter int PATCH_WIDTH   = 55,
    parameter int DIM           = 5,
    parameter int COMP_WIDTH    = 11,
    parameter int ADDRESS_WIDTH = 8,
    parameter int LEAF_SIZE     = 8,
    parameter int SLOT_WIDTH    = 3,
    parameter int DIST_WIDTH    = 16
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [PATCH_WIDTH-1:0]              patch_in,
    input  logic [ADDRESS_WIDTH-1:0]            leaf_index,
    output logic                                mem_ren,
    output logic [ADDRESS_WIDTH+SLOT_WIDTH-1:0] mem_addr,
    input  logic [PATCH_WIDTH-1:0]              mem_rdata,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [DIST_WIDTH-1:0]               out_dist,
    output logic [ADDRESS_WIDTH+SLOT_WIDTH-1:0] out_idx
);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

    state_t                              state, state_nxt;
    logic                                accept;
    logic [SLOT_WIDTH-1:0]               slot;
    logic [SLOT_WIDTH-1:0]               rd_slot;
    logic                                rd_valid;
    logic [ADDRESS_WIDTH-1:0]            leaf_q;
    logic [PATCH_WIDTH-1:0]              query_q;
    logic [DIST_WIDTH-1:0]               sad;
    logic [DIST_WIDTH-1:0]               best_dist;
    logic [ADDRESS_WIDTH+SLOT_WIDTH-1:0] best_idx;
    logic [COMP_WIDTH-1:0]               q_comp, c_comp, diff;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        mem_ren   = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept    = 1'b1;
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                mem_ren = 1'b1;
                if (slot == SLOT_WIDTH'(LEAF_SIZE - 1)) state_nxt = DRAIN;
            end
            DRAIN: state_nxt = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign mem_addr = {leaf_q, slot};
    assign out_dist = best_dist;
    assign out_idx  = best_idx;

    always_comb begin
        sad    = '0;
        q_comp = '0;
        c_comp = '0;
        diff   = '0;
        for (int unsigned k = 0; k < DIM; k++) begin
            q_comp = query_q[k*COMP_WIDTH +: COMP_WIDTH];
            c_comp = mem_rdata[k*COMP_WIDTH +: COMP_WIDTH];
            diff   = (q_comp >= c_comp) ? (q_comp - c_comp) : (c_comp - q_comp);
            sad    = sad + DIST_WIDTH'(diff);
        end
    end

    // rd_valid/rd_slot track the slot whose data arrives on mem_rdata this cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            leaf_q    <= '0;
            query_q   <= '0;
            slot      <= '0;
            rd_valid  <= 1'b0;
            rd_slot   <= '0;
            best_dist <= '0;
            best_idx  <= '0;
        end else begin
            if (accept) begin
                leaf_q  <= leaf_index;
                query_q <= patch_in;
                slot    <= '0;
            end else if (mem_ren) begin
                slot <= slot + 1'b1;
            end
            rd_valid <= mem_ren;
            rd_slot  <= slot;
            if (rd_valid && (rd_slot == '0 || sad < best_dist)) begin
                best_dist <= sad;
                best_idx  <= {leaf_q, rd_slot};
            end
        end
    end

endmodule

// File: tb/tb_leaf_nn_search.sv
// Directed bench for leaf_nn_search: table of queries with hand-computed
// best candidates, plus back-pressure and reset corner-case sequences.
module tb_leaf_nn_search;

    localparam int PW = 55;
    localparam int AW = 8;
    localparam int SW = 3;
    localparam int DW = 16;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [PW-1:0] patch_in;
    logic [AW-1:0] leaf_index;
    logic          mem_ren;
    logic [AW+SW-1:0] mem_addr;
    logic [PW-1:0] mem_rdata;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_dist;
    logic [AW+SW-1:0] out_idx;

    leaf_nn_search #(
        .PATCH_WIDTH(PW), .DIM(5), .COMP_WIDTH(11), .ADDRESS_WIDTH(AW),
        .LEAF_SIZE(8), .SLOT_WIDTH(SW), .DIST_WIDTH(DW)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .patch_in(patch_in), .leaf_index(leaf_index), .mem_ren(mem_ren),
        .mem_addr(mem_addr), .mem_rdata(mem_rdata), .out_valid(out_valid),
        .out_ready(out_ready), .out_dist(out_dist), .out_idx(out_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [PW-1:0] mem [0:2047];
    always @(posedge clk) if (mem_ren) mem_rdata <= mem[mem_addr];

    // Candidate of a slot: component 0 = c0, components 1..4 = cv.
    typedef struct packed {
        logic [7:0]  leaf;
        logic [10:0] q;
        logic [87:0] cv;
        logic [87:0] c0;
        logic [10:0] exp_idx;
        logic [15:0] exp_dist;
    } vec_t;

    vec_t vecs [5];
    int   n_vec = 0;
    int   n_err = 0;
    int   cur   = 0;

    function automatic logic [87:0] pk(input int a0, a1, a2, a3, a4, a5, a6, a7);
        logic [87:0] r;
        int a [8];
        a = '{a0, a1, a2, a3, a4, a5, a6, a7};
        for (int i = 0; i < 8; i++) r[i*11 +: 11] = 11'(a[i]);
        return r;
    endfunction

    function automatic logic [PW-1:0] mk(input logic [10:0] c0, input logic [10:0] cv);
        logic [PW-1:0] r;
        r = {5{cv}};
        r[10:0] = c0;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL vec%0d %s: got %0h, expected %0h", cur, name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int bp);
        for (int s = 0; s < 8; s++)
            mem[{v.leaf, 3'(s)}] = mk(v.c0[s*11 +: 11], v.cv[s*11 +: 11]);
        @(negedge clk);
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        patch_in   = mk(v.q, v.q);
        leaf_index = v.leaf;
        in_valid   = 1'b1;
        out_ready  = (bp == 0);
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        patch_in   = '1;
        leaf_index = ~v.leaf;
        for (int s = 0; s < 8; s++) begin
            @(negedge clk);
            chk("mem_ren_fetch", 32'(mem_ren), 32'd1);
            chk("mem_addr", 32'(mem_addr), 32'({v.leaf, 3'(s)}));
            chk("in_ready_busy", 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        chk("mem_ren_drain", 32'(mem_ren), 32'd0);
        chk("out_valid_early", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("out_valid", 32'(out_valid), 32'd1);
        chk("out_idx", 32'(out_idx), 32'(v.exp_idx));
        chk("out_dist", 32'(out_dist), 32'(v.exp_dist));
        if (bp > 0) begin
            patch_in   = mk(11'd0, 11'd0);
            leaf_index = 8'h01;
            in_valid   = 1'b1;
            for (int c = 0; c < bp; c++) begin
                @(negedge clk);
                chk("bp_hold", {2'b0, out_valid, in_ready, mem_ren, out_idx, out_dist},
                    {2'b0, 1'b1, 1'b0, 1'b0, v.exp_idx, v.exp_dist});
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
        @(negedge clk);
        chk("in_ready_back", 32'(in_ready), 32'd1);
        chk("out_valid_drop", 32'(out_valid), 32'd0);
    endtask

    initial begin
        rst        = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        patch_in   = '0;
        leaf_index = '0;
        for (int i = 0; i < 2048; i++) mem[i] = '0;

        vecs[0] = '{leaf: 8'h2A, q: 11'd100,
                    cv: pk(150, 140, 130, 103, 120, 110, 160, 170),
                    c0: pk(150, 140, 130, 103, 120, 110, 160, 170),
                    exp_idx: 11'h153, exp_dist: 16'd15};
        vecs[1] = '{leaf: 8'h05, q: 11'd500,
                    cv: pk(500, 500, 500, 500, 500, 500, 500, 500),
                    c0: pk(520, 510, 507, 530, 509, 493, 600, 508),
                    exp_idx: 11'h02A, exp_dist: 16'd7};
        vecs[2] = '{leaf: 8'hFF, q: 11'd0,
                    cv: pk(2047, 2047, 2047, 2047, 2047, 2047, 2047, 0),
                    c0: pk(2047, 2047, 2047, 2047, 2047, 2047, 2047, 0),
                    exp_idx: 11'h7FF, exp_dist: 16'd0};
        vecs[3] = '{leaf: 8'h3C, q: 11'd2047,
                    cv: pk(0, 10, 20, 30, 40, 50, 2000, 1000),
                    c0: pk(0, 10, 20, 30, 40, 50, 2000, 1000),
                    exp_idx: 11'h1E6, exp_dist: 16'd235};
        vecs[4] = '{leaf: 8'h80, q: 11'd7,
                    cv: pk(7, 7, 7, 7, 7, 7, 7, 7),
                    c0: pk(7, 7, 7, 7, 7, 7, 7, 7),
                    exp_idx: 11'h400, exp_dist: 16'd0};

        // Asynchronous reset before the first clock edge.
        #2 rst = 1'b1;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_outs", {8'b0, mem_ren, out_valid, mem_addr, 11'b0},
            {8'b0, 1'b0, 1'b0, 11'd0, 11'b0});
        chk("rst_result", {5'b0, out_idx, out_dist}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            cur = i;
            run_vec(vecs[i], 0);
        end

        cur = 5;
        run_vec(vecs[3], 20);

        // Abort a query at slot 4; its leaf would otherwise give distance 0.
        cur = 6;
        for (int s = 0; s < 8; s++) mem[{8'h11, 3'(s)}] = '0;
        @(negedge clk);
        patch_in   = '0;
        leaf_index = 8'h11;
        in_valid   = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("abort_addr", 32'(mem_addr), 32'({8'h11, 3'd4}));
        #2 rst = 1'b1;
        #1;
        chk("abort_rst", {27'b0, mem_ren, out_valid, in_ready, 2'b0}, {27'b0, 1'b0, 1'b0, 1'b1, 2'b0});
        chk("abort_addr_rst", 32'(mem_addr), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            chk("abort_quiet", {29'b0, mem_ren, out_valid, in_ready}, {29'b0, 1'b0, 1'b0, 1'b1});
        end
        cur = 7;
        run_vec(vecs[1], 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
